// File: rtl/timer_poll_master.sv
// Avalon-MM master that programs a timer slave, polls for timeouts and counts them.
// Optional snapshot readback is compiled in with TIMER_POLL_MASTER_SNAPSHOT_EN.
module timer_poll_master (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_start,
   input  logic        cmd_stop,
   input  logic [31:0] cmd_period,
   input  logic        cmd_continuous,
   output logic        busy,
   output logic        tick_pulse,
   output logic [15:0] tick_count,
   output logic [31:0] snap_value,
   output logic [2:0]  av_address,
   output logic        av_chipselect,
   output logic        av_write_n,
   output logic [15:0] av_writedata,
   input  logic [15:0] av_readdata
);

   localparam int unsigned PERIOD_W = 32;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned CNT_W    = 16;

   localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_PERL    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_PERH    = ADDR_W'(3);
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
   localparam logic [ADDR_W-1:0] ADDR_SNAPL   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_SNAPH   = ADDR_W'(5);
`endif

   localparam logic [DATA_W-1:0] CTRL_START = DATA_W'(16'h0004);
   localparam logic [DATA_W-1:0] CTRL_STOP  = DATA_W'(16'h0008);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      WR_PL   = 4'd1,
      WR_PH   = 4'd2,
      WR_CTRL = 4'd3,
      POLL_A  = 4'd4,
      POLL_D  = 4'd5,
      CLR_STS = 4'd6,
      STOP_WR = 4'd7
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
      ,
      SNAP_W  = 4'd8,
      SNAPL_A = 4'd9,
      SNAPL_D = 4'd10,
      SNAPH_A = 4'd11,
      SNAPH_D = 4'd12
`endif
   } state_t;

   state_t              state_q, state_d, next_step;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                cont_q, cont_d;
   logic                stop_pend_q, stop_pend_d;
   logic                stop_req;
   logic                busy_q, busy_d;
   logic                tick_pulse_q, tick_pulse_d;
   logic [CNT_W-1:0]    tick_count_q, tick_count_d;
   logic                cs_q, cs_d, wn_q, wn_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wd_q, wd_d;
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
   logic [DATA_W-1:0]   snap_lo_q, snap_lo_d;
   logic [PERIOD_W-1:0] snap_value_q, snap_value_d;
`endif

   // Next state, bookkeeping, and bus outputs decoded from the next state so they register with it.
   always_comb begin
      state_d      = state_q;
      period_d     = period_q;
      cont_d       = cont_q;
      stop_pend_d  = stop_pend_q;
      tick_count_d = tick_count_q;
      tick_pulse_d = 1'b0;
      cs_d         = 1'b0;
      wn_d         = 1'b1;
      addr_d       = ADDR_STATUS;
      wd_d         = '0;
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
      snap_lo_d    = snap_lo_q;
      snap_value_d = snap_value_q;
`endif
      stop_req  = stop_pend_q | cmd_stop;
      next_step = stop_req ? STOP_WR : (cont_q ? POLL_A : IDLE);

      case (state_q)
         IDLE: begin
            if (cmd_stop) begin
               state_d = STOP_WR;
            end else if (cmd_start && (cmd_period != '0)) begin
               period_d     = cmd_period;
               cont_d       = cmd_continuous;
               tick_count_d = '0;
               state_d      = WR_PL;
            end
         end
         WR_PL:   state_d = WR_PH;
         WR_PH:   state_d = WR_CTRL;
         WR_CTRL: state_d = stop_req ? STOP_WR : POLL_A;
         POLL_A:  state_d = POLL_D;
         POLL_D: begin
            if (av_readdata[0])  state_d = CLR_STS;
            else if (stop_req)   state_d = STOP_WR;
            else                 state_d = POLL_A;
         end
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
         CLR_STS: state_d = SNAP_W;
         SNAP_W:  state_d = SNAPL_A;
         SNAPL_A: state_d = SNAPL_D;
         SNAPL_D: begin
            snap_lo_d = av_readdata;
            state_d   = SNAPH_A;
         end
         SNAPH_A: state_d = SNAPH_D;
         SNAPH_D: begin
            snap_value_d = {av_readdata, snap_lo_q};
            state_d      = next_step;
         end
`else
         CLR_STS: state_d = next_step;
`endif
         STOP_WR: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A stop seen while busy is held until a decision point consumes it.
      if ((state_q != IDLE) && cmd_stop) stop_pend_d = 1'b1;
      if ((state_d == STOP_WR) || (state_d == IDLE)) stop_pend_d = 1'b0;

      if (state_d == CLR_STS) begin
         tick_pulse_d = 1'b1;
         tick_count_d = tick_count_q + CNT_W'(1);
      end

      busy_d = (state_d != IDLE);

      case (state_d)
         WR_PL: begin
            cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERL;
            wd_d = period_d[DATA_W-1:0];
         end
         WR_PH: begin
            cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERH;
            wd_d = period_d[PERIOD_W-1:DATA_W];
         end
         WR_CTRL: begin
            cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;
            wd_d = CTRL_START | (DATA_W'(cont_d) << 1);
         end
         POLL_A, POLL_D: begin
            cs_d = 1'b1; addr_d = ADDR_STATUS;
         end
         CLR_STS: begin
            cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;
         end
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
         SNAP_W: begin
            cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_SNAPL;
         end
         SNAPL_A, SNAPL_D: begin
            cs_d = 1'b1; addr_d = ADDR_SNAPL;
         end
         SNAPH_A, SNAPH_D: begin
            cs_d = 1'b1; addr_d = ADDR_SNAPH;
         end
`endif
         STOP_WR: begin
            cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;
            wd_d = CTRL_STOP;
         end
         default: begin
            cs_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         period_q     <= '0;
         cont_q       <= 1'b0;
         stop_pend_q  <= 1'b0;
         busy_q       <= 1'b0;
         tick_pulse_q <= 1'b0;
         tick_count_q <= '0;
         cs_q         <= 1'b0;
         wn_q         <= 1'b1;
         addr_q       <= '0;
         wd_q         <= '0;
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
         snap_lo_q    <= '0;
         snap_value_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         cont_q       <= cont_d;
         stop_pend_q  <= stop_pend_d;
         busy_q       <= busy_d;
         tick_pulse_q <= tick_pulse_d;
         tick_count_q <= tick_count_d;
         cs_q         <= cs_d;
         wn_q         <= wn_d;
         addr_q       <= addr_d;
         wd_q         <= wd_d;
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
         snap_lo_q    <= snap_lo_d;
         snap_value_q <= snap_value_d;
`endif
      end
   end

   assign busy          = busy_q;
   assign tick_pulse    = tick_pulse_q;
   assign tick_count    = tick_count_q;
   assign av_chipselect = cs_q;
   assign av_write_n    = wn_q;
   assign av_address    = addr_q;
   assign av_writedata  = wd_q;
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
   assign snap_value    = snap_value_q;
`else
   // Only the status bit is consumed when snapshot readback is absent.
   logic unused_rd;
   assign unused_rd  = ^av_readdata[DATA_W-1:1];
   assign snap_value = '0;
`endif

endmodule

// File: tb/tb_timer_poll_master.sv
// Scoreboard bench for timer_poll_master with a small Avalon timer-slave model.
// Define TIMER_POLL_MASTER_SNAPSHOT_EN for both files to exercise snapshot readback.
module tb_timer_poll_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_start = 1'b0;
   logic        cmd_stop = 1'b0;
   logic [31:0] cmd_period = '0;
   logic        cmd_continuous = 1'b0;
   logic        busy, tick_pulse;
   logic [15:0] tick_count;
   logic [31:0] snap_value;
   logic [2:0]  av_address;
   logic        av_chipselect, av_write_n;
   logic [15:0] av_writedata;
   logic [15:0] av_readdata = '0;

   int n_vec = 0;
   int n_err = 0;
   int ticks_seen = 0;
   int writes_seen = 0;
   logic [18:0] exp_q[$];
   logic [18:0] mon_e;

   // Slave model state: status fires after a short countdown, limited to fire_limit clears.
   int cnt = 3;
   int clears = 0;
   int fire_limit = 0;

   always #5 clk = ~clk;

   timer_poll_master dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop),
      .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
      .busy(busy), .tick_pulse(tick_pulse), .tick_count(tick_count),
      .snap_value(snap_value),
      .av_address(av_address), .av_chipselect(av_chipselect),
      .av_write_n(av_write_n), .av_writedata(av_writedata),
      .av_readdata(av_readdata)
   );

   always @(posedge clk) begin
      if (av_chipselect && av_write_n) begin
         case (av_address)
            3'd0: begin
               av_readdata <= {15'd0, (cnt == 0) && (clears < fire_limit)};
               if (cnt != 0) cnt <= cnt - 1;
            end
            3'd4:    av_readdata <= 16'h1234;
            3'd5:    av_readdata <= 16'h0001;
            default: av_readdata <= 16'h0000;
         endcase
      end else if (av_chipselect && !av_write_n) begin
         if (av_address == 3'd0) begin
            clears <= clears + 1;
            cnt    <= 3;
         end
         if (av_address == 3'd1 && av_writedata[2]) cnt <= 3;
      end
   end

   // Monitor: every bus write is popped from the expected queue and compared.
   always @(posedge clk) begin
      #1;
      if (tick_pulse) ticks_seen++;
      if (av_chipselect && !av_write_n) begin
         writes_seen++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bus_write: got %h@%0d, required no write", av_writedata, av_address);
         end else begin
            mon_e = exp_q.pop_front();
            if ({av_address, av_writedata} !== mon_e) begin
               n_err++;
               $display("FAIL bus_write: got %h@%0d, required %h@%0d",
                        av_writedata, av_address, mon_e[15:0], mon_e[18:16]);
            end
         end
      end
`ifndef TIMER_POLL_MASTER_SNAPSHOT_EN
      if (av_chipselect && av_address > 3'd3) begin
         n_vec++;
         n_err++;
         $display("FAIL snap_addr_access: got address %0d, required <= 3", av_address);
      end
`endif
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic push_tick();
      push(3'd0, 16'h0000);
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
      push(3'd4, 16'h0000);
`endif
   endtask

   task automatic start(input logic [31:0] p, input logic c);
      @(negedge clk);
      cmd_period = p;
      cmd_continuous = c;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles, input string name);
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   initial begin
      int t0;
      int w0;
      logic [31:0] exp_snap;
`ifdef TIMER_POLL_MASTER_SNAPSHOT_EN
      exp_snap = 32'h0001_1234;
`else
      exp_snap = 32'h0000_0000;
`endif
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tick_pulse", 32'(tick_pulse), 32'd0);
      chk("rst_tick_count", 32'(tick_count), 32'd0);
      chk("rst_snap", snap_value, 32'd0);
      chk("rst_cs", 32'(av_chipselect), 32'd0);
      chk("rst_wn", 32'(av_write_n), 32'd1);
      chk("rst_addr", 32'(av_address), 32'd0);
      chk("rst_wd", 32'(av_writedata), 32'd0);
      reset_n = 1'b1;

      // One-shot
      fire_limit = clears + 1;
      push(3'd2, 16'h2E97); push(3'd3, 16'h0002); push(3'd1, 16'h0004); push_tick();
      t0 = ticks_seen;
      start(32'h0002_2E97, 1'b0);
      wait_idle(300, "oneshot_idle");
      chk("oneshot_tick_count", 32'(tick_count), 32'd1);
      chk("oneshot_pulses", 32'(ticks_seen - t0), 32'd1);
      chk("oneshot_snap", snap_value, exp_snap);
      chk("oneshot_queue", 32'(exp_q.size()), 32'd0);

      // Continuous, three timeouts then stop during polling
      fire_limit = clears + 3;
      push(3'd2, 16'h0005); push(3'd3, 16'h0000); push(3'd1, 16'h0006);
      push_tick(); push_tick(); push_tick();
      t0 = ticks_seen;
      start(32'd5, 1'b1);
      for (int i = 0; i < 600; i++) begin
         if (ticks_seen - t0 >= 3) break;
         @(negedge clk);
      end
      repeat (12) @(negedge clk);
      chk("cont_pulses", 32'(ticks_seen - t0), 32'd3);
      chk("cont_tick_count", 32'(tick_count), 32'd3);
      chk("cont_still_busy", 32'(busy), 32'd1);
      push(3'd1, 16'h0008);
      @(negedge clk); cmd_stop = 1'b1;
      @(negedge clk); cmd_stop = 1'b0;
      wait_idle(50, "stop_idle");
      chk("stop_tick_count", 32'(tick_count), 32'd3);
      chk("stop_queue", 32'(exp_q.size()), 32'd0);

      // Zero period start is ignored
      w0 = writes_seen;
      start(32'd0, 1'b1);
      repeat (10) @(negedge clk);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_no_writes", 32'(writes_seen - w0), 32'd0);

      // Simultaneous start and stop in IDLE: stop only
      push(3'd1, 16'h0008);
      @(negedge clk);
      cmd_period = 32'd7; cmd_continuous = 1'b0; cmd_start = 1'b1; cmd_stop = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; cmd_stop = 1'b0;
      wait_idle(20, "simul_idle");
      repeat (5) @(negedge clk);
      chk("simul_tick_count", 32'(tick_count), 32'd3);
      chk("simul_queue", 32'(exp_q.size()), 32'd0);

      // Reset during WR_PH
      push(3'd2, 16'h0011); push(3'd3, 16'h0022);
      @(negedge clk);
      cmd_period = 32'h0022_0011; cmd_continuous = 1'b0; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_cs", 32'(av_chipselect), 32'd0);
      chk("midrst_wn", 32'(av_write_n), 32'd1);
      chk("midrst_addr", 32'(av_address), 32'd0);
      chk("midrst_wd", 32'(av_writedata), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_tick_count", 32'(tick_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      w0 = writes_seen;
      repeat (20) @(negedge clk);
      chk("midrst_no_writes", 32'(writes_seen - w0), 32'd0);
      chk("midrst_queue", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
